dms_lvl_slicer: RTL and testbench
=================================

Name: dms_lvl_slicer

Overview:
- Downstream stage of the DMS FIR low-pass filter.
- Consumes the filtered real-valued signal as a clocked sample stream.
- Per window of samples, measures peak-to-peak amplitude and midpoint threshold, and declares lock when the amplitude is sufficient.
- While locked, slices each sample to a bit against the midpoint threshold, for the downstream CDR/data logic.

Parameters:
- WIN_LEN, 64: accepted samples per measurement window; must be >= 2.
- MIN_AMP, 0.05: real; minimum peak-to-peak amplitude for a window to count as strong.
- LOSS_CNT, 2: consecutive weak windows in TRACK that drop lock; must be >= 1.
- HYST, 0.1: real; hysteresis fraction of the locked amplitude (used only with the optional feature).

Ports:
- clk, in, 1: sample clock.
- rst, in, 1: reset; synchronous, active-high.
- din, in, real: filtered input sample from the FIR stage.
- din_en, in, 1: sample strobe; din is accepted on a clk edge only when din_en=1.
- bit_out, out, 1: sliced data bit.
- bit_vld, out, 1: one-cycle pulse; bit_out is new this cycle.
- amp, out, real: peak-to-peak amplitude of the last completed window.
- thr, out, real: slicing threshold, the midpoint of the last strong window.
- locked, out, 1: 1 while in TRACK.
- win_done, out, 1: one-cycle pulse when a window completes.

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on posedge clk.
- Reset values:
  - bit_out=0, bit_vld=0, amp=0.0, thr=0.0, locked=0, win_done=0.
  - State=ACQ; win_cnt, weak_cnt, cur_max, cur_min, lock_amp all cleared.
- Reset mid-window discards the partial window. The next window needs WIN_LEN fresh accepted samples.
- din_en=0 cycle: no internal state change; bit_vld=0 and win_done=0 that cycle; amp, thr, bit_out hold.
- Window accumulation, per accepted sample:
  - If win_cnt==0: cur_max=cur_min=din.
  - Otherwise: cur_max=max(cur_max,din), cur_min=min(cur_min,din).
  - win_cnt increments and wraps to 0 after WIN_LEN-1.
- Window completion: the accepted sample with win_cnt==WIN_LEN-1 completes the window, with that sample included in max/min. At that same edge:
  - win_done=1 for one cycle.
  - amp=max-min, updated every window.
  - Window is strong if amp >= MIN_AMP, otherwise weak.
  - Strong window: thr=(max+min)/2, lock_amp=amp, weak_cnt=0.
  - Weak window: thr and lock_amp hold.
- State machine:
  - ACQ, strong window -> TRACK; locked=1 asserts in the same cycle as win_done.
  - ACQ, weak window -> stay in ACQ.
  - TRACK, weak window: weak_cnt+1. When weak_cnt reaches LOSS_CNT -> ACQ, locked=0 in the same cycle as win_done, weak_cnt=0.
  - TRACK, strong window -> stay in TRACK.
- Slicing:
  - Decision uses the state and thr registered before the edge at which the sample is accepted.
  - State TRACK: at the accepting edge, bit_out=(din > thr) and bit_vld=1 for one cycle. Latency is 1 clk from accept.
  - State ACQ: bit_vld=0 and bit_out holds.
  - The sample that completes the locking window is not sliced. Slicing starts with the next accepted sample.
  - The sample that completes the window dropping lock is still sliced.
- Boundaries:
  - din==thr gives 0 (strict compare).
  - A window of constant input gives amp=0.0 (weak unless MIN_AMP<=0).
  - A threshold update and a slice in the same cycle: the slice uses the old thr.

Optional Feature:
- Macro: DMS_SLICER_HYST_EN.
- Defined:
  - h=HYST*lock_amp.
  - In TRACK, bit_out goes to 1 only if din > thr+h, and to 0 only if din < thr-h; otherwise it holds.
  - bit_vld still pulses for every sliced sample.
  - h uses lock_amp as registered before the edge.
- Undefined: plain comparison din > thr; lock_amp is unused and may be removed.

Test Plan:
1. Reset: rst=1 for 3 clk, din=0.7, din_en=1 -> all outputs at reset values, locked=0, no win_done.
2. Lock and slice (WIN_LEN=4, din_en=1 every cycle). Input 0.0, 1.0, 0.0, -1.0 repeating:
   - After the 4th sample: win_done=1, amp=2.0, thr=0.0, locked=1.
   - Next four samples: bit_out 0, 1, 0, 0, each with bit_vld=1.
3. Loss of lock (LOSS_CNT=2), after test 2, din=0.3 constant for 8 samples:
   - First win_done: amp=0.0, locked stays 1.
   - Second win_done: amp=0.0, locked=0, thr stays 0.0.
   - Then bit_vld=0.
4. Strobe gating: din_en toggles 1/0 with the test 2 pattern -> window completes after 4 accepted samples (8 clk); bit_vld and win_done are never asserted on din_en=0 cycles.
5. Reset mid-window: 2 samples accepted, rst for 1 clk -> win_done occurs only after 4 further accepted samples; amp reflects only those 4.
6. Hysteresis (macro defined, HYST=0.1, lock_amp=2.0, thr=0.0, bit_out=0). din 0.1 -> 0; 0.3 -> 1; -0.1 -> 1; -0.3 -> 0. Macro undefined, same sequence -> 1, 1, 0, 0.

Source files
------------

// File: rtl/dms_lvl_slicer.sv
// Level slicer behind the DMS FIR: per-window peak-to-peak/midpoint measurement,
// lock tracking and bit slicing. Define DMS_SLICER_HYST_EN for a hysteresis band.
module dms_lvl_slicer #(
    parameter int  WIN_LEN  = 64,
    parameter real MIN_AMP  = 0.05,
    parameter int  LOSS_CNT = 2,
    parameter real HYST     = 0.1
) (
    input  logic clk,
    input  logic rst,
    input  real  din,
    input  logic din_en,
    output logic bit_out,
    output logic bit_vld,
    output real  amp,
    output real  thr,
    output logic locked,
    output logic win_done
);

    localparam int CW  = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam int WCW = $clog2(LOSS_CNT + 1);

    if (WIN_LEN < 2 || LOSS_CNT < 1 || HYST < 0.0) begin : g_param_check
        $error("dms_lvl_slicer: WIN_LEN must be >= 2, LOSS_CNT >= 1, HYST >= 0");
    end

    typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    win_cnt_q, win_cnt_d;
    logic [WCW-1:0]   weak_cnt_q, weak_cnt_d;
    real              cur_max_q, cur_max_d;
    real              cur_min_q, cur_min_d;
    real              amp_q, amp_d;
    real              thr_q, thr_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_vld_q, bit_vld_d;
    logic             locked_q, locked_d;
    logic             win_done_q, win_done_d;
    real              nxt_max, nxt_min, win_amp;
`ifdef DMS_SLICER_HYST_EN
    real              lock_amp_q, lock_amp_d;
    real              hyst_h;
`endif

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        weak_cnt_d = weak_cnt_q;
        cur_max_d  = cur_max_q;
        cur_min_d  = cur_min_q;
        amp_d      = amp_q;
        thr_d      = thr_q;
        bit_out_d  = bit_out_q;
        bit_vld_d  = 1'b0;
        win_done_d = 1'b0;
        nxt_max    = (win_cnt_q == '0 || din > cur_max_q) ? din : cur_max_q;
        nxt_min    = (win_cnt_q == '0 || din < cur_min_q) ? din : cur_min_q;
        win_amp    = nxt_max - nxt_min;
`ifdef DMS_SLICER_HYST_EN
        lock_amp_d = lock_amp_q;
        hyst_h     = HYST * lock_amp_q;
`endif

        if (din_en) begin
            // Slice against the state and threshold held before this edge.
            if (state_q == TRACK) begin
                bit_vld_d = 1'b1;
`ifdef DMS_SLICER_HYST_EN
                if (din > thr_q + hyst_h) begin
                    bit_out_d = 1'b1;
                end else if (din < thr_q - hyst_h) begin
                    bit_out_d = 1'b0;
                end
`else
                bit_out_d = (din > thr_q);
`endif
            end

            cur_max_d = nxt_max;
            cur_min_d = nxt_min;

            if (win_cnt_q == CW'(WIN_LEN - 1)) begin
                win_cnt_d  = '0;
                win_done_d = 1'b1;
                amp_d      = win_amp;
                if (win_amp >= MIN_AMP) begin
                    thr_d      = (nxt_max + nxt_min) / 2.0;
                    weak_cnt_d = '0;
                    state_d    = TRACK;
`ifdef DMS_SLICER_HYST_EN
                    lock_amp_d = win_amp;
`endif
                end else if (state_q == TRACK) begin
                    if (int'(weak_cnt_q) + 1 >= LOSS_CNT) begin
                        weak_cnt_d = '0;
                        state_d    = ACQ;
                    end else begin
                        weak_cnt_d = weak_cnt_q + WCW'(1);
                    end
                end
            end else begin
                win_cnt_d = win_cnt_q + CW'(1);
            end
        end

        locked_d = (state_d == TRACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACQ;
            win_cnt_q  <= '0;
            weak_cnt_q <= '0;
            cur_max_q  <= 0.0;
            cur_min_q  <= 0.0;
            amp_q      <= 0.0;
            thr_q      <= 0.0;
            bit_out_q  <= 1'b0;
            bit_vld_q  <= 1'b0;
            locked_q   <= 1'b0;
            win_done_q <= 1'b0;
`ifdef DMS_SLICER_HYST_EN
            lock_amp_q <= 0.0;
`endif
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            weak_cnt_q <= weak_cnt_d;
            cur_max_q  <= cur_max_d;
            cur_min_q  <= cur_min_d;
            amp_q      <= amp_d;
            thr_q      <= thr_d;
            bit_out_q  <= bit_out_d;
            bit_vld_q  <= bit_vld_d;
            locked_q   <= locked_d;
            win_done_q <= win_done_d;
`ifdef DMS_SLICER_HYST_EN
            lock_amp_q <= lock_amp_d;
`endif
        end
    end

    assign bit_out  = bit_out_q;
    assign bit_vld  = bit_vld_q;
    assign amp      = amp_q;
    assign thr      = thr_q;
    assign locked   = locked_q;
    assign win_done = win_done_q;

endmodule

// File: tb/tb_dms_lvl_slicer.sv
// Self-checking bench for dms_lvl_slicer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a window model.
module tb_dms_lvl_slicer;

    localparam int  WIN_LEN  = 4;
    localparam real MIN_AMP  = 0.05;
    localparam int  LOSS_CNT = 2;
    localparam real HYST     = 0.1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    real  din = 0.0;
    logic din_en = 1'b0;
    logic bit_out, bit_vld, locked, win_done;
    real  amp, thr;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    dms_lvl_slicer #(
        .WIN_LEN (WIN_LEN),
        .MIN_AMP (MIN_AMP),
        .LOSS_CNT(LOSS_CNT),
        .HYST    (HYST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_en  (din_en),
        .bit_out (bit_out),
        .bit_vld (bit_vld),
        .amp     (amp),
        .thr     (thr),
        .locked  (locked),
        .win_done(win_done)
    );

    always #5 clk = ~clk;

    // Reference model: a queue holds the current window, judged when full.
    real q[$];
    bit  m_trk, m_bit, m_vld, m_done;
    int  m_weak;
    real m_amp, m_thr, m_la;

    always @(posedge clk) begin
        real mx, mn, h;
        if (rst) begin
            q.delete();
            m_trk = 0; m_bit = 0; m_vld = 0; m_done = 0; m_weak = 0;
            m_amp = 0.0; m_thr = 0.0; m_la = 0.0;
        end else begin
            m_vld  = 0;
            m_done = 0;
            if (din_en) begin
                if (m_trk) begin
                    m_vld = 1;
`ifdef DMS_SLICER_HYST_EN
                    h = HYST * m_la;
                    if (din > m_thr + h) m_bit = 1;
                    else if (din < m_thr - h) m_bit = 0;
`else
                    h = 0.0;
                    m_bit = (din > m_thr);
`endif
                end
                q.push_back(din);
                if (q.size() == WIN_LEN) begin
                    mx = q[0];
                    mn = q[0];
                    foreach (q[i]) begin
                        if (q[i] > mx) mx = q[i];
                        if (q[i] < mn) mn = q[i];
                    end
                    m_amp  = mx - mn;
                    m_done = 1;
                    if (m_amp >= MIN_AMP) begin
                        m_thr  = (mx + mn) / 2.0;
                        m_la   = m_amp;
                        m_weak = 0;
                        m_trk  = 1;
                    end else if (m_trk) begin
                        m_weak++;
                        if (m_weak >= LOSS_CNT) begin
                            m_trk  = 0;
                            m_weak = 0;
                        end
                    end
                    q.delete();
                end
            end
        end
    end

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_r(input string name, input real act, input real exp);
        checks++;
        if (act > exp + 1e-9 || act < exp - 1e-9) begin
            errors++;
            $display("FAIL %s: got %f expected %f at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare, on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk_b("model_bit_vld", bit_vld, m_vld);
            chk_b("model_win_done", win_done, m_done);
            chk_b("model_locked", locked, m_trk);
            chk_r("model_amp", amp, m_amp);
            chk_r("model_thr", thr, m_thr);
            if (m_vld) chk_b("model_bit_out", bit_out, m_bit);
        end
    end

    task automatic step(input logic en, input real d);
        din_en = en;
        din    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step(1'b1, 0.7);
        rst = 1'b0;
    endtask

    real pat[4] = '{0.0, 1.0, 0.0, -1.0};
    real hseq[4] = '{0.1, 0.3, -0.1, -0.3};
    logic exp_bits[4];

    initial begin
        #1;
        cmp_en = 1'b1;

        // Reset with active strobe and nonzero input
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 0.7);
            chk_b("rst_bit_out", bit_out, 1'b0);
            chk_b("rst_bit_vld", bit_vld, 1'b0);
            chk_r("rst_amp", amp, 0.0);
            chk_r("rst_thr", thr, 0.0);
            chk_b("rst_locked", locked, 1'b0);
            chk_b("rst_win_done", win_done, 1'b0);
        end
        rst = 1'b0;

        // Lock, then slice
        for (int i = 0; i < 4; i++) step(1'b1, pat[i]);
        chk_b("lock_win_done", win_done, 1'b1);
        chk_r("lock_amp", amp, 2.0);
        chk_r("lock_thr", thr, 0.0);
        chk_b("lock_locked", locked, 1'b1);
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pat[i]);
            chk_b("slice_vld", bit_vld, 1'b1);
            chk_b("slice_bit", bit_out, exp_bits[i]);
        end

        // Loss of lock on constant input
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 0.3);
            if (i == 3) begin
                chk_b("loss1_done", win_done, 1'b1);
                chk_r("loss1_amp", amp, 0.0);
                chk_b("loss1_locked", locked, 1'b1);
            end
        end
        chk_b("loss2_done", win_done, 1'b1);
        chk_r("loss2_amp", amp, 0.0);
        chk_b("loss2_locked", locked, 1'b0);
        chk_r("loss2_thr", thr, 0.0);
        chk_b("loss2_last_sliced", bit_vld, 1'b1);
        step(1'b1, 0.3);
        chk_b("loss_no_vld", bit_vld, 1'b0);

        // Strobe gating
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            step((i % 2) == 0, pat[i / 2]);
            if (i == 5) chk_b("gate_not_yet", win_done, 1'b0);
        end
        chk_b("gate_idle_done", win_done, 1'b0);
        chk_b("gate_locked", locked, 1'b1);
        chk_r("gate_amp", amp, 2.0);

        // Reset mid-window discards the partial window
        do_reset(1);
        step(1'b1, 5.0);
        step(1'b1, -5.0);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pat[i]);
            if (i == 2) chk_b("midrst_not_yet", win_done, 1'b0);
        end
        chk_b("midrst_done", win_done, 1'b1);
        chk_r("midrst_amp", amp, 2.0);

        // Slicing with thr=0.0, lock_amp=2.0, bit_out=0
        chk_b("hyst_pre_bit", bit_out, 1'b0);
`ifdef DMS_SLICER_HYST_EN
        exp_bits = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_bits = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b1, hseq[i]);
            chk_b("hyst_bit", bit_out, exp_bits[i]);
        end

        // Slice exactly at the threshold
        step(1'b1, 1.0);
        step(1'b1, 0.0);
        chk_b("eq_thr_zero", bit_out, 1'b0);

        // Randomized traffic
        begin
            real scale;
            scale = 1.0;
            for (int n = 0; n < 1500; n++) begin
                if (n % 8 == 0) begin
                    case ($urandom_range(0, 3))
                        0: scale = 0.0;
                        1: scale = 0.1;
                        default: scale = 1.0;
                    endcase
                end
                rst = ($urandom_range(0, 199) == 0);
                step($urandom_range(0, 9) < 7,
                     real'(int'($urandom_range(0, 8)) - 4) * 0.25 * scale);
            end
            rst = 1'b0;
        end

        step(1'b0, 0.0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
